// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared encodings for the LED pattern engine: pattern modes, speed selects,
// bounce direction, and the seed() helper that gives the pattern loaded on a
// mode/direction change.
// -----------------------------------------------------------------------------
package led_pattern_pkg;

  // Widest LED bank that seed() can describe.
  localparam int unsigned MAX_LED_W = 64;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SPEED_SLOW    = 2'd0,
    SPEED_FAST    = 2'd1,
    SPEED_CUSTOM  = 2'd2,
    SPEED_CUSTOM2 = 2'd3
  } speed_e;

  typedef enum logic {
    BNC_UP   = 1'b0,  // moving toward MSB
    BNC_DOWN = 1'b1   // moving toward LSB
  } bounce_dir_e;

  // Pattern reloaded when mode or direction changes. The caller truncates the
  // result to its own LED width.
  function automatic logic [MAX_LED_W-1:0] seed(mode_e mode, logic dir,
                                                int unsigned led_w);
    logic [MAX_LED_W-1:0] one;
    one = {{(MAX_LED_W-1){1'b0}}, 1'b1};
    case (mode)
      MODE_FILL:   seed = '0;
      MODE_ROTATE: seed = dir ? (one << (led_w - 1)) : one;
      default:     seed = one;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Step-rate counter. Counts up to div_i and emits a one-cycle tick when the
// count reaches or passes the divisor, so the step period is div_i+1 cycles.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   pause_i  : freeze the count, suppress ticks
//   clear_i  : force count to zero this cycle, suppress ticks (mode change)
//   div_i    : current divisor (may change at any time)
//   tick_o   : combinational tick, valid in the compare cycle
// -----------------------------------------------------------------------------
module led_tick_gen #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pause_i,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  // >= rather than == so that lowering the divisor below the running count
  // still produces a tick on the next cycle instead of a full wrap.
  assign tick_o = !pause_i && !clear_i && (cnt_q >= div_i);

  // NOTE: sequential state is assigned with <= so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (pause_i) begin
      cnt_q <= cnt_q;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
// Drives LED_W LEDs with a rotate, bounce, fill-bar or hold pattern. The step
// rate comes from two preset divisors or a runtime-loaded custom divisor.
//   s00_axi_aclk   : clock
//   s00_axi_areset : synchronous active-high reset
//   i_mode         : 0 rotate, 1 bounce, 2 fill, 3 hold
//   i_dir          : 0 toward MSB, 1 toward LSB (rotate/fill)
//   i_speed        : 0 SLOW_DIV, 1 FAST_DIV, 2/3 custom divisor
//   i_pause        : freeze counter and pattern
//   i_div_wr       : load i_div_val into the custom divisor
//   i_div_val      : custom divisor value
//   i_bright       : PWM duty 0..15 (LED_PWM_EN builds only)
//   o_led          : LED drive (registered)
//   o_step         : one-cycle pulse per pattern step
//   o_wrap         : one-cycle pulse on wrap, bounce reversal or fill clear
// Build option: define LED_PWM_EN to gate o_led with a 16-phase brightness
// PWM; without it o_led is the pattern register and i_bright is ignored.
// -----------------------------------------------------------------------------
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned SLOW_DIV = 20_000_000,
  parameter int unsigned FAST_DIV = 4_000_000
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_areset,
  input  logic [1:0]       i_mode,
  input  logic             i_dir,
  input  logic [1:0]       i_speed,
  input  logic             i_pause,
  input  logic             i_div_wr,
  input  logic [DIV_W-1:0] i_div_val,
  input  logic [3:0]       i_bright,
  output logic [LED_W-1:0] o_led,
  output logic             o_step,
  output logic             o_wrap
);

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};

  mode_e            mode_in;
  mode_e            mode_q;
  logic             dir_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_sel;
  logic [LED_W-1:0] pattern_q, pattern_d;
  bounce_dir_e      bdir_q, bdir_d;
  logic             wrap_d;
  logic             step_q, wrap_q;
  logic             change;
  logic             tick;

  assign mode_in = mode_e'(i_mode);

  // Change is judged against last cycle's inputs; it clears the counter
  // even when entering hold, but hold keeps the current pattern.
  assign change = (mode_in != mode_q) || (i_dir != dir_q);

  always_comb begin
    case (speed_e'(i_speed))
      SPEED_SLOW: div_sel = DIV_W'(SLOW_DIV);
      SPEED_FAST: div_sel = DIV_W'(FAST_DIV);
      default:    div_sel = div_q;
    endcase
  end

  led_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk_i   (s00_axi_aclk),
    .rst_i   (s00_axi_areset),
    .pause_i (i_pause),
    .clear_i (change),
    .div_i   (div_sel),
    .tick_o  (tick)
  );

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    pattern_d = pattern_q;
    bdir_d    = bdir_q;
    wrap_d    = 1'b0;
    if (change) begin
      if (mode_in != MODE_HOLD) begin
        pattern_d = LED_W'(seed(mode_in, i_dir, LED_W));
        bdir_d    = BNC_UP;
      end
    end else if (tick) begin
      case (mode_in)
        MODE_ROTATE: begin
          if (!i_dir) begin
            pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
            wrap_d    = pattern_q[LED_W-1];
          end else begin
            pattern_d = {pattern_q[0], pattern_q[LED_W-1:1]};
            wrap_d    = pattern_q[0];
          end
        end
        MODE_BOUNCE: begin
          // At an end, reverse and move one step inward in the same tick.
          if (bdir_q == BNC_UP) begin
            if (pattern_q[LED_W-1]) begin
              pattern_d = pattern_q >> 1;
              bdir_d    = BNC_DOWN;
              wrap_d    = 1'b1;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              pattern_d = pattern_q << 1;
              bdir_d    = BNC_UP;
              wrap_d    = 1'b1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        MODE_FILL: begin
          if (&pattern_q) begin
            pattern_d = '0;
            wrap_d    = 1'b1;
          end else if (!i_dir) begin
            pattern_d = {pattern_q[LED_W-2:0], 1'b1};
          end else begin
            pattern_d = {1'b1, pattern_q[LED_W-1:1]};
          end
        end
        default: begin
          pattern_d = pattern_q;
        end
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      pattern_q <= LED_ONE;
      bdir_q    <= BNC_UP;
      mode_q    <= MODE_ROTATE;
      dir_q     <= 1'b0;
      div_q     <= DIV_W'(SLOW_DIV);
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      if (!i_pause || change) begin
        pattern_q <= pattern_d;
        bdir_q    <= bdir_d;
      end
      mode_q <= mode_in;
      dir_q  <= i_dir;
      if (i_div_wr) begin
        div_q <= i_div_val;
      end
      step_q <= tick;
      wrap_q <= wrap_d;
    end
  end

  assign o_step = step_q;
  assign o_wrap = wrap_q;

`ifdef LED_PWM_EN
  logic [3:0]       pwm_cnt_q;
  logic [LED_W-1:0] led_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      pwm_cnt_q <= 4'd0;
      led_q     <= LED_ONE;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      led_q     <= pattern_q & {LED_W{pwm_cnt_q < i_bright}};
    end
  end

  assign o_led = led_q;
`else
  logic unused_bright;
  assign unused_bright = ^i_bright;
  assign o_led         = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_engine
// Directed bench for led_pattern_engine with LED_W=4, SLOW_DIV=3, FAST_DIV=1.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_led_pattern_engine;

  localparam int unsigned LED_W = 4;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             areset;
  logic [1:0]       mode;
  logic             dir;
  logic [1:0]       speed;
  logic             pause;
  logic             div_wr;
  logic [DIV_W-1:0] div_val;
  logic [3:0]       bright;
  logic [LED_W-1:0] led;
  logic             step;
  logic             wrap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_pattern_engine #(
    .LED_W    (LED_W),
    .DIV_W    (DIV_W),
    .SLOW_DIV (3),
    .FAST_DIV (1)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (areset),
    .i_mode         (mode),
    .i_dir          (dir),
    .i_speed        (speed),
    .i_pause        (pause),
    .i_div_wr       (div_wr),
    .i_div_val      (div_val),
    .i_bright       (bright),
    .o_led          (led),
    .o_step         (step),
    .o_wrap         (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifndef LED_PWM_EN
  logic [3:0] rot_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic       rot_wrp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] bnc_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                              4'b0010, 4'b0001, 4'b0010};
  logic       bnc_wrp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] fil_exp [6] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                              4'b0000, 4'b1000};
  logic       fil_wrp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

  initial begin
    areset  = 1'b1;
    mode    = 2'd0;
    dir     = 1'b0;
    speed   = 2'd0;
    pause   = 1'b0;
    div_wr  = 1'b0;
    div_val = '0;
    bright  = 4'd0;
    edges(2);
    check("reset_led",  32'(led),  32'h1);
    check("reset_step", 32'(step), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    areset = 1'b0;

`ifndef LED_PWM_EN
    // Rotate toward MSB, period 4.
    for (int i = 0; i < 4; i++) begin
      edges(3);
      check("rot_idle", 32'(step), 32'h0);
      edges(1);
      check("rot_led",  32'(led),  32'(rot_exp[i]));
      check("rot_step", 32'(step), 32'h1);
      check("rot_wrap", 32'(wrap), 32'(rot_wrp[i]));
    end

    // Bounce at FAST_DIV=1, period 2.
    mode  = 2'd1;
    speed = 2'd1;
    edges(1);
    check("bnc_seed", 32'(led),  32'h1);
    check("bnc_nostep", 32'(step), 32'h0);
    for (int i = 0; i < 7; i++) begin
      edges(2);
      check("bnc_led",  32'(led),  32'(bnc_exp[i]));
      check("bnc_wrap", 32'(wrap), 32'(bnc_wrp[i]));
    end

    // Fill toward LSB with custom divisor 0: a step every cycle.
    mode    = 2'd2;
    dir     = 1'b1;
    speed   = 2'd2;
    div_wr  = 1'b1;
    div_val = '0;
    edges(1);
    div_wr = 1'b0;
    check("fil_seed", 32'(led), 32'h0);
    for (int i = 0; i < 6; i++) begin
      edges(1);
      check("fil_led",  32'(led),  32'(fil_exp[i]));
      check("fil_step", 32'(step), 32'h1);
      check("fil_wrap", 32'(wrap), 32'(fil_wrp[i]));
    end

    // Pause at cnt=2 under rotate, div=3.
    mode  = 2'd0;
    dir   = 1'b0;
    speed = 2'd0;
    edges(1);
    check("pau_seed", 32'(led), 32'h1);
    edges(2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check("pau_led",  32'(led),  32'h1);
      check("pau_step", 32'(step), 32'h0);
    end
    pause = 1'b0;
    edges(1);
    check("pau_rel1_step", 32'(step), 32'h0);
    edges(1);
    check("pau_rel2_step", 32'(step), 32'h1);
    check("pau_rel2_led",  32'(led),  32'h2);
    edges(4);
    check("pre_sw_led", 32'(led), 32'h4);

    // Switch rotate -> fill at 0100: cleared pattern and count.
    mode = 2'd2;
    edges(1);
    check("sw_led",  32'(led),  32'h0);
    check("sw_step", 32'(step), 32'h0);
    edges(3);
    check("sw_cnt_led",  32'(led),  32'h0);
    check("sw_cnt_step", 32'(step), 32'h0);
    edges(1);
    check("sw_fill_led",  32'(led),  32'h1);
    check("sw_fill_step", 32'(step), 32'h1);

    // Reset mid-run, with other inputs busy.
    areset = 1'b1;
    mode   = 2'd1;
    speed  = 2'd1;
    pause  = 1'b1;
    edges(1);
    check("mid_rst_led",  32'(led),  32'h1);
    check("mid_rst_step", 32'(step), 32'h0);
    check("mid_rst_wrap", 32'(wrap), 32'h0);

    // Hold: entering keeps the pattern; steps still pulse without wrap.
    areset = 1'b0;
    pause  = 1'b0;
    mode   = 2'd3;
    edges(1);
    check("hold_enter_led", 32'(led),  32'h1);
    edges(1);
    check("hold_idle_step", 32'(step), 32'h0);
    edges(1);
    check("hold_step", 32'(step), 32'h1);
    check("hold_led",  32'(led),  32'h1);
    check("hold_wrap", 32'(wrap), 32'h0);
`else
    // PWM: pattern held at 0001, duty from i_bright.
    begin
      int on_cnt;
      mode   = 2'd3;
      bright = 4'd4;
      edges(2);
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        edges(1);
        if (led[0]) on_cnt++;
      end
      check("pwm_duty4", 32'(on_cnt), 32'd4);
      bright = 4'd0;
      edges(2);
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        edges(1);
        if (led != '0) on_cnt++;
      end
      check("pwm_duty0", 32'(on_cnt), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
